// File: rtl/hls_run_pkg.sv
// Shared types and defaults for the HLS run sequencer and related harness blocks.
package hls_run_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrst,
    StStart,
    StWait,
    StReport,
    StFin
  } run_state_e;

  localparam int unsigned DefaultTimeout = 200000000;
  localparam int unsigned DefaultCycW    = 32;
  localparam int unsigned DefaultRunW    = 8;

  typedef struct packed {
    logic [DefaultRunW-1:0] idx;
    logic [DefaultCycW-1:0] cycles;
    logic                   timeout;
  } run_result_t;

endpackage

// File: rtl/hls_run_watchdog.sv
// Loadable, saturating cycle counter with a compare-to-TIMEOUT flag.
module hls_run_watchdog
  import hls_run_pkg::*;
#(
  parameter int unsigned CYC_W   = 32,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [CYC_W-1:0] count_o,
  output logic             hit_o
);

  logic [CYC_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CYC_W'(1);
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign hit_o   = (count_q == CYC_W'(TIMEOUT));

endmodule

// File: rtl/hls_run_sequencer.sv
// Sequences N back-to-back runs of an HLS accelerator: DUT reset, start, wait, report.
// Optional per-sequence min/max/sum statistics when HLS_RUN_SEQ_STATS_EN is defined.
module hls_run_sequencer
  import hls_run_pkg::*;
#(
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned RUN_W      = 8,
  parameter int unsigned TIMEOUT    = DefaultTimeout,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   go,
  input  logic [RUN_W-1:0]       num_runs,
  output logic                   dut_reset,
  output logic                   dut_start,
  input  logic                   dut_done,
  output logic                   run_valid,
  output logic [RUN_W-1:0]       run_idx,
  output logic [CYC_W-1:0]       run_cycles,
  output logic                   run_timeout,
  output logic                   busy,
  output logic                   seq_done,
  output logic                   seq_aborted
`ifdef HLS_RUN_SEQ_STATS_EN
  ,
  output logic [CYC_W-1:0]       stat_min,
  output logic [CYC_W-1:0]       stat_max,
  output logic [CYC_W+RUN_W-1:0] stat_sum
`endif
);

  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_e       state_d, state_q;
  logic [RstW-1:0]  rst_cnt_d, rst_cnt_q;
  logic [RUN_W-1:0] count_d, count_q;
  logic [RUN_W-1:0] idx_d, idx_q;
  logic [RUN_W-1:0] run_idx_d, run_idx_q;
  logic [CYC_W-1:0] run_cycles_d, run_cycles_q;
  logic             run_timeout_d, run_timeout_q;
  logic             run_valid_d, run_valid_q;
  logic             dut_reset_d, dut_reset_q;
  logic             dut_start_d, dut_start_q;
  logic             busy_d, busy_q;
  logic             seq_done_d, seq_done_q;
  logic             seq_aborted_d, seq_aborted_q;

  logic             go_acc, rep, rep_to;
  logic [CYC_W-1:0] rep_cycles;
  logic [CYC_W-1:0] wd_count;
  logic             wd_hit;

  hls_run_watchdog #(
    .CYC_W  (CYC_W),
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i  (clock),
    .rst_i  (reset),
    .load_i (state_q == StStart),
    .inc_i  (state_q == StWait),
    .count_o(wd_count),
    .hit_o  (wd_hit)
  );

`ifdef HLS_RUN_SEQ_STATS_EN
  logic [CYC_W-1:0]       stat_min_d, stat_min_q;
  logic [CYC_W-1:0]       stat_max_d, stat_max_q;
  logic [CYC_W+RUN_W-1:0] stat_sum_d, stat_sum_q;
`endif

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    count_d       = count_q;
    idx_d         = idx_q;
    run_idx_d     = run_idx_q;
    run_cycles_d  = run_cycles_q;
    run_timeout_d = run_timeout_q;
    seq_aborted_d = seq_aborted_q;
    go_acc        = 1'b0;
    rep           = 1'b0;
    rep_to        = 1'b0;
    rep_cycles    = '0;

    case (state_q)
      StIdle: begin
        if (go) begin
          go_acc        = 1'b1;
          seq_aborted_d = 1'b0;
          if (num_runs != '0) begin
            count_d   = num_runs;
            idx_d     = '0;
            run_idx_d = '0;
            rst_cnt_d = '0;
            state_d   = StDrst;
          end else begin
            state_d = StFin;
          end
        end
      end
      StDrst: begin
        if (rst_cnt_q == RstW'(RST_CYCLES - 1)) begin
          state_d = StStart;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      StStart: begin
        if (dut_done) begin
          rep        = 1'b1;
          rep_cycles = CYC_W'(1);
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        // Done takes priority over a coincident watchdog hit.
        if (dut_done) begin
          rep        = 1'b1;
          rep_cycles = wd_count + CYC_W'(1);
        end else if (wd_hit) begin
          rep        = 1'b1;
          rep_to     = 1'b1;
          rep_cycles = CYC_W'(TIMEOUT);
        end
      end
      StReport: begin
        if (run_timeout_q || (idx_q == count_q - RUN_W'(1))) begin
          state_d = StFin;
        end else begin
          idx_d     = idx_q + RUN_W'(1);
          rst_cnt_d = '0;
          state_d   = StDrst;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (rep) begin
      state_d       = StReport;
      run_idx_d     = idx_q;
      run_cycles_d  = rep_cycles;
      run_timeout_d = rep_to;
      if (rep_to) begin
        seq_aborted_d = 1'b1;
      end
    end

`ifdef HLS_RUN_SEQ_STATS_EN
    stat_min_d = stat_min_q;
    stat_max_d = stat_max_q;
    stat_sum_d = stat_sum_q;
    if (go_acc) begin
      stat_min_d = '1;
      stat_max_d = '0;
      stat_sum_d = '0;
    end else if (rep && !rep_to) begin
      if (rep_cycles < stat_min_q) stat_min_d = rep_cycles;
      if (rep_cycles > stat_max_q) stat_max_d = rep_cycles;
      stat_sum_d = stat_sum_q + {{RUN_W{1'b0}}, rep_cycles};
    end
`endif

    // Outputs are registered and track the state being entered.
    dut_reset_d = (state_d == StIdle) || (state_d == StDrst);
    dut_start_d = (state_d == StStart);
    run_valid_d = (state_d == StReport);
    seq_done_d  = (state_d == StFin);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      rst_cnt_q     <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      run_idx_q     <= '0;
      run_cycles_q  <= '0;
      run_timeout_q <= 1'b0;
      run_valid_q   <= 1'b0;
      dut_reset_q   <= 1'b1;
      dut_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      seq_done_q    <= 1'b0;
      seq_aborted_q <= 1'b0;
`ifdef HLS_RUN_SEQ_STATS_EN
      stat_min_q    <= '1;
      stat_max_q    <= '0;
      stat_sum_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      run_idx_q     <= run_idx_d;
      run_cycles_q  <= run_cycles_d;
      run_timeout_q <= run_timeout_d;
      run_valid_q   <= run_valid_d;
      dut_reset_q   <= dut_reset_d;
      dut_start_q   <= dut_start_d;
      busy_q        <= busy_d;
      seq_done_q    <= seq_done_d;
      seq_aborted_q <= seq_aborted_d;
`ifdef HLS_RUN_SEQ_STATS_EN
      stat_min_q    <= stat_min_d;
      stat_max_q    <= stat_max_d;
      stat_sum_q    <= stat_sum_d;
`endif
    end
  end

  assign dut_reset   = dut_reset_q;
  assign dut_start   = dut_start_q;
  assign run_valid   = run_valid_q;
  assign run_idx     = run_idx_q;
  assign run_cycles  = run_cycles_q;
  assign run_timeout = run_timeout_q;
  assign busy        = busy_q;
  assign seq_done    = seq_done_q;
  assign seq_aborted = seq_aborted_q;
`ifdef HLS_RUN_SEQ_STATS_EN
  assign stat_min    = stat_min_q;
  assign stat_max    = stat_max_q;
  assign stat_sum    = stat_sum_q;
`endif

endmodule
